// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the external memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Read data returned to the owner when an access times out.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection for the shared memory port: data has priority, but after
// STARVE_LIMIT consecutive data grants taken while fetch waited, fetch wins.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,    // arbiter is idle and may grant this cycle
  input  logic if_req,
  input  logic d_req,
  output logic win_vld,
  output logic win_own
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] streak;

  // Pick the winner among the pending requests.
  always_comb begin
    win_vld = if_req | d_req;
    win_own = OWN_IF;
    if (d_req && !(if_req && streak == LIMIT))
      win_own = OWN_D;
  end

  // Streak counts data grants that made a waiting fetch lose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (arb_en && win_vld) begin
      if (win_own == OWN_D && if_req)
        streak <= (streak == LIMIT) ? streak : streak + 4'd1;
      else
        streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data port.
// One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE.
// Optional macro ARB_TIMEOUT_EN: bounded ACCESS wait with sticky timeout_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ext_mem_addr,
  output logic [DATA_W-1:0] ext_mem_wdata,
  output logic              ext_mem_write,
  output logic              ext_mem_read,
  input  logic [DATA_W-1:0] ext_mem_rdata,
  input  logic              ext_mem_ready,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
    $error("STARVE_LIMIT out of range 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t            state, state_nxt;
  logic              win_vld, win_own;
  logic              acc_tmo, acc_done;
  logic              lat_we;
  logic [DATA_W-1:0] cap_data;

  arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (state == IDLE),
    .if_req  (if_req),
    .d_req   (d_req),
    .win_vld (win_vld),
    .win_own (win_own)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  assign acc_tmo  = (wait_cnt == TMO_LAST) && !ext_mem_ready;
  // ready wins over a coincident timeout, so real data is never discarded
  assign cap_data = ext_mem_ready ? ext_mem_rdata : DATA_W'(TIMEOUT_DATA);

  // Count ACCESS cycles; entry to ACCESS is always from IDLE, so clear there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE)
        wait_cnt <= '0;
      else if (state == ACCESS)
        wait_cnt <= wait_cnt + 16'd1;
      if (state == ACCESS && acc_tmo)
        timeout_err <= 1'b1;
    end
  end
`else
  assign acc_tmo     = 1'b0;
  assign cap_data    = ext_mem_rdata;
  assign timeout_err = 1'b0;
`endif

  assign acc_done = ext_mem_ready | acc_tmo;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)  state_nxt = ACCESS;
      ACCESS:  if (acc_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request, pulse its grant, capture read data on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_mem_addr  <= '0;
      ext_mem_wdata <= '0;
      lat_we        <= 1'b0;
      owner         <= OWN_IF;
      if_gnt        <= 1'b0;
      d_gnt         <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt  <= 1'b0;
      if (state == IDLE && win_vld) begin
        owner         <= win_own;
        ext_mem_addr  <= (win_own == OWN_D) ? d_addr : if_addr;
        ext_mem_wdata <= (win_own == OWN_D) ? d_wdata : '0;
        lat_we        <= (win_own == OWN_D) && d_we;
        if_gnt        <= (win_own == OWN_IF);
        d_gnt         <= (win_own == OWN_D);
      end
      if (state == ACCESS && acc_done) begin
        if (owner == OWN_IF)
          if_rdata <= cap_data;
        else if (!lat_we || !ext_mem_ready)
          d_rdata  <= cap_data;
      end
    end
  end

  // Strobes decode straight from state so reset drops them immediately.
  assign ext_mem_read  = (state == ACCESS) && !lat_we;
  assign ext_mem_write = (state == ACCESS) &&  lat_we;
  assign busy          = (state != IDLE);
  assign if_valid      = (state == RESP) && (owner == OWN_IF);
  assign d_valid       = (state == RESP) && (owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of arbitration and read data.
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, ext_mem_ready;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata, ext_mem_rdata;
  logic        if_gnt, if_valid, d_gnt, d_valid;
  logic [31:0] if_rdata, d_rdata, ext_mem_wdata;
  logic [15:0] ext_mem_addr;
  logic        ext_mem_write, ext_mem_read, owner, busy, timeout_err;

  int          checks = 0;
  int          failures = 0;
  int          streak;
  logic [31:0] m_if_rd, m_d_rd;
  int          cnt;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .ext_mem_addr(ext_mem_addr), .ext_mem_wdata(ext_mem_wdata),
    .ext_mem_write(ext_mem_write), .ext_mem_read(ext_mem_read),
    .ext_mem_rdata(ext_mem_rdata), .ext_mem_ready(ext_mem_ready),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_flags", {if_gnt, if_valid, d_gnt, d_valid, ext_mem_write, ext_mem_read,
                      owner, busy, timeout_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ext_addr", {16'd0, ext_mem_addr}, 32'd0);
    chk("rst_ext_wdata", ext_mem_wdata, 32'd0);
  endtask

  // One complete transaction from the currently pending requests.
  // rearm keeps the winner's request high; poke_d pulses d_req mid-ACCESS.
  task automatic txn(input int waits, input logic [31:0] rd, input bit rearm,
                     input bit poke_d, output bit won_d);
    bit          wd, we;
    logic [15:0] ea;
    logic [31:0] ew;
    wd = d_req && (!if_req || streak < SL);
    if (wd && if_req) streak = (streak < SL) ? streak + 1 : SL;
    else              streak = 0;
    won_d = wd;
    ea = wd ? d_addr : if_addr;
    we = wd && d_we;
    ew = d_wdata;
    @(posedge clk); @(negedge clk);
    chk("if_gnt", if_gnt, !wd);
    chk("d_gnt", d_gnt, wd);
    chk("owner", owner, wd);
    chk("busy_access", busy, 1);
    chk("rd_strobe", ext_mem_read, !we);
    chk("wr_strobe", ext_mem_write, we);
    chk("ext_addr", {16'd0, ext_mem_addr}, {16'd0, ea});
    if (we) chk("ext_wdata", ext_mem_wdata, ew);
    if (!rearm) begin
      if (wd) d_req = 1'b0;
      else    if_req = 1'b0;
    end
    ext_mem_rdata = rd;
    ext_mem_ready = (waits == 0);
    for (int i = 0; i < waits; i++) begin
      if (poke_d) d_req = (i == 0);
      @(posedge clk); @(negedge clk);
      chk("gnt_quiet", {if_gnt, d_gnt}, 0);
      chk("strobe_hold", {ext_mem_write, ext_mem_read}, we ? 2 : 1);
      chk("addr_hold", {16'd0, ext_mem_addr}, {16'd0, ea});
      if (i == waits - 1) ext_mem_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    ext_mem_ready = 1'b0;
    if (wd) begin
      if (!we) m_d_rd = rd;
    end else begin
      m_if_rd = rd;
    end
    chk("if_valid", if_valid, !wd);
    chk("d_valid", d_valid, wd);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata", d_rdata, m_d_rd);
    chk("strobes_resp", {ext_mem_write, ext_mem_read}, 0);
    chk("busy_resp", busy, 1);
    @(posedge clk); @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("valid_idle", {if_valid, d_valid}, 0);
  endtask

  initial begin
    bit          wd;
    bit [9:0]    ord;
    int          r;
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; ext_mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; ext_mem_rdata = '0;
    streak = 0; m_if_rd = '0; m_d_rd = '0;
    #3;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b0;

    // single fetch with two wait cycles
    if_req = 1; if_addr = 16'h0040;
    txn(2, 32'h0000_0013, 0, 0, wd);

    // data write, immediate ready; d_rdata must not change
    d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 32'hCAFE_0001;
    txn(0, 32'h1234_5678, 0, 0, wd);

    // continuous contention: starvation limiter forces every fifth grant to fetch
    if_req = 1; if_addr = 16'h0200;
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    for (int k = 0; k < 10; k++) begin
      txn(0, $urandom, 1, 0, wd);
      ord[k] = wd;
    end
    chk("grant_order", {22'd0, ord}, {22'd0, 10'b0111101111});
    if_req = 0; d_req = 0;

    // d_req pulse during a fetch ACCESS is ignored
    d_we = 0; d_addr = 16'h0444;
    if_req = 1; if_addr = 16'h0080;
    txn(3, 32'hA5A5_0001, 0, 1, wd);

    // ready in IDLE does nothing
    ext_mem_ready = 1;
    @(posedge clk); @(negedge clk);
    chk("idle_ready_busy", busy, 0);
    chk("idle_ready_strb", {ext_mem_write, ext_mem_read}, 0);
    ext_mem_ready = 0;
    @(posedge clk); @(negedge clk);
    chk("idle_ready_valid", {if_valid, d_valid}, 0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if (!if_req && !d_req) begin
        r = $urandom_range(1, 3);
        if (r[0]) begin if_req = 1; if_addr = 16'($urandom); end
        if (r[1]) begin d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = $urandom; end
      end else if ($urandom_range(0, 1) == 1) begin
        if (!if_req) begin if_req = 1; if_addr = 16'($urandom); end
        else if (!d_req) begin d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = $urandom; end
      end
      txn($urandom_range(0, 3), $urandom, 0, 0, wd);
    end
    if_req = 0; d_req = 0;

    // reset in the middle of an ACCESS
    if_req = 1; if_addr = 16'h0500;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_read", ext_mem_read, 1);
    if_req = 0;
    #2 rst = 1'b1;
    #1 chk_reset_outs();
    @(negedge clk);
    rst = 1'b0;
    streak = 0; m_if_rd = '0; m_d_rd = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_valid", {if_valid, d_valid}, 0);
      chk("post_rst_busy", busy, 0);
    end
    d_req = 1; d_we = 0; d_addr = 16'h0600;
    txn(1, 32'h0BAD_F00D, 0, 0, wd);

`ifdef ARB_TIMEOUT_EN
    // ready never arrives: strobe must drop after TC ACCESS cycles
    d_req = 1; d_we = 0; d_addr = 16'h0700;
    @(posedge clk); @(negedge clk);
    chk("tmo_gnt", d_gnt, 1);
    d_req = 0;
    streak = 0;
    cnt = 0;
    for (int i = 0; i < 40 && ext_mem_read; i++) begin
      cnt++;
      @(posedge clk); @(negedge clk);
    end
    chk("tmo_cycles", cnt, TC);
    chk("tmo_valid", d_valid, 1);
    chk("tmo_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("tmo_err", timeout_err, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("tmo_err_sticky", timeout_err, 1);
    end
    rst = 1'b1;
    #1 chk("tmo_err_rst", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
`else
    chk("tmo_err_off", timeout_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
